// File: rtl/neokeon_pkg.sv
// Shared types, constants and the Noekeon step functions (Theta, Pi1, Gamma, Pi2)
// used by the round datapath and the controller.
// Optional decryption support is enabled with the NEOKEON_DECRYPT_EN macro.
package neokeon_pkg;

    localparam int         NR          = 16;
    localparam logic [7:0] RC_INIT     = 8'h80;
    localparam logic [7:0] RC_DEC_INIT = 8'hD4;

    // 128-bit cipher state; word a0 is bits [127:96], a3 is bits [31:0].
    typedef logic [127:0] nk_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } fsm_e;

    // Forward round-constant step: multiply by x in GF(2^8) mod 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
    endfunction

    // Inverse of xtime, used to walk the constants backwards when decrypting.
    function automatic logic [7:0] inv_xtime(input logic [7:0] rc);
        return rc[0] ? (((rc ^ 8'h1B) >> 1) | 8'h80) : (rc >> 1);
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Theta: linear mixing with the working key added between the two halves.
    function automatic nk_state_t nk_theta(input nk_state_t k, input nk_state_t s);
        logic [31:0] a0, a1, a2, a3, t;
        a0 = s[127:96];
        a1 = s[95:64];
        a2 = s[63:32];
        a3 = s[31:0];
        t  = a0 ^ a2;
        t  = t ^ rotl32(t, 8) ^ rotl32(t, 24);
        a1 = a1 ^ t;
        a3 = a3 ^ t;
        a0 = a0 ^ k[127:96];
        a1 = a1 ^ k[95:64];
        a2 = a2 ^ k[63:32];
        a3 = a3 ^ k[31:0];
        t  = a1 ^ a3;
        t  = t ^ rotl32(t, 8) ^ rotl32(t, 24);
        a0 = a0 ^ t;
        a2 = a2 ^ t;
        return {a0, a1, a2, a3};
    endfunction

    function automatic nk_state_t nk_pi1(input nk_state_t s);
        return {s[127:96], rotl32(s[95:64], 1), rotl32(s[63:32], 5), rotl32(s[31:0], 2)};
    endfunction

    function automatic nk_state_t nk_pi2(input nk_state_t s);
        return {s[127:96], rotl32(s[95:64], 31), rotl32(s[63:32], 27), rotl32(s[31:0], 30)};
    endfunction

    // Gamma: the nonlinear bit-sliced S-box layer (an involution).
    function automatic nk_state_t nk_gamma(input nk_state_t s);
        logic [31:0] a0, a1, a2, a3, t;
        a0 = s[127:96];
        a1 = s[95:64];
        a2 = s[63:32];
        a3 = s[31:0];
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        t  = a3;
        a3 = a0;
        a0 = t;
        a2 = a2 ^ a0 ^ a1 ^ a3;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        return {a0, a1, a2, a3};
    endfunction

endpackage

// File: rtl/neokeon_round.sv
// Combinational Noekeon round: Theta, Pi1, Gamma, Pi2 chained, with the round
// constant injected either before Theta (encrypt) or after Theta (decrypt).
// theta_o is the constant-adjusted Theta result, used for the final half-round.
module neokeon_round
    import neokeon_pkg::*;
(
    input  nk_state_t  state_i,
    input  nk_state_t  key_i,
    input  logic [7:0] rc_i,
    input  logic       rc_post_i,
    output nk_state_t  round_o,
    output nk_state_t  theta_o
);

    nk_state_t rc_vec;
    nk_state_t theta_in;
    nk_state_t theta_res;

    // The constant always lands in the top byte of word a0.
    assign rc_vec    = {rc_i, 120'b0};
    assign theta_in  = rc_post_i ? state_i : (state_i ^ rc_vec);
    assign theta_res = nk_theta(key_i, theta_in);
    assign theta_o   = rc_post_i ? (theta_res ^ rc_vec) : theta_res;
    assign round_o   = nk_pi2(nk_gamma(nk_pi1(theta_o)));

endmodule

// File: rtl/neokeon_round_ctrl.sv
// Iterative Noekeon-128 controller (direct-key mode): one round per clock,
// 16 rounds then a final Theta, with a start/valid handshake.
// Handshake: inStart is accepted only while outBusy=0 (FSM idle); outValid is a
// one-cycle pulse and outDataState then holds until the next result is written.
// Optional decryption support is enabled with the NEOKEON_DECRYPT_EN macro.
module neokeon_round_ctrl #(
    parameter int         NR      = 16,
    parameter logic [7:0] RC_INIT = 8'h80
) (
    input  logic         inClk,
    input  logic         inRst,
    input  logic         inStart,
    input  logic [127:0] inDataState,
    input  logic [127:0] inDataKey,
    input  logic         inDecrypt,
    output logic         outBusy,
    output logic         outValid,
    output logic [127:0] outDataState,
    output logic [4:0]   outRound
);

    import neokeon_pkg::*;

    localparam logic [4:0] LAST_ROUND = 5'(NR - 1);

    fsm_e       fsm_q, fsm_d;
    nk_state_t  state_q, state_d;
    nk_state_t  key_q, key_d;
    nk_state_t  out_q, out_d;
    logic [7:0] rc_q, rc_d;
    logic [7:0] rc_next;
    logic [4:0] round_q, round_d;
    logic       valid_q, valid_d;
    logic       rc_post;
    nk_state_t  round_out;
    nk_state_t  theta_out;

`ifdef NEOKEON_DECRYPT_EN
    logic dec_q, dec_d;

    assign rc_post = dec_q;
    assign rc_next = dec_q ? inv_xtime(rc_q) : xtime(rc_q);
`else
    logic unused_decrypt;

    assign unused_decrypt = inDecrypt;
    assign rc_post        = 1'b0;
    assign rc_next        = xtime(rc_q);
`endif

    neokeon_round u_round (
        .state_i   (state_q),
        .key_i     (key_q),
        .rc_i      (rc_q),
        .rc_post_i (rc_post),
        .round_o   (round_out),
        .theta_o   (theta_out)
    );

    // Next-state logic: latch on start, iterate rounds, emit the final half-round.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        out_d   = out_q;
        rc_d    = rc_q;
        round_d = round_q;
        valid_d = 1'b0;
`ifdef NEOKEON_DECRYPT_EN
        dec_d   = dec_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (inStart) begin
                    state_d = inDataState;
                    key_d   = inDataKey;
                    rc_d    = RC_INIT;
                    round_d = '0;
                    fsm_d   = ROUND;
`ifdef NEOKEON_DECRYPT_EN
                    dec_d   = inDecrypt;
                    if (inDecrypt) begin
                        // Decryption runs the same rounds with K' = Theta(0, K).
                        key_d = nk_theta('0, inDataKey);
                        rc_d  = RC_DEC_INIT;
                    end
`endif
                end
            end
            ROUND: begin
                state_d = round_out;
                rc_d    = rc_next;
                round_d = round_q + 5'd1;
                if (round_q == LAST_ROUND) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                out_d   = theta_out;
                valid_d = 1'b1;
                fsm_d   = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            out_q   <= '0;
            rc_q    <= RC_INIT;
            round_q <= '0;
            valid_q <= 1'b0;
`ifdef NEOKEON_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            out_q   <= out_d;
            rc_q    <= rc_d;
            round_q <= round_d;
            valid_q <= valid_d;
`ifdef NEOKEON_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign outBusy      = (fsm_q != IDLE);
    assign outValid     = valid_q;
    assign outDataState = out_q;
    assign outRound     = round_q;

endmodule

// File: tb/tb_neokeon_round_ctrl.sv
// Self-checking bench for neokeon_round_ctrl with a word-level Noekeon model.
// Decryption checks are compiled in when NEOKEON_DECRYPT_EN is defined.
module tb_neokeon_round_ctrl;

    logic         inClk = 1'b0;
    logic         inRst;
    logic         inStart;
    logic [127:0] inDataState;
    logic [127:0] inDataKey;
    logic         inDecrypt;
    logic         outBusy;
    logic         outValid;
    logic [127:0] outDataState;
    logic [4:0]   outRound;

    int checks   = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

    neokeon_round_ctrl dut (
        .inClk        (inClk),
        .inRst        (inRst),
        .inStart      (inStart),
        .inDataState  (inDataState),
        .inDataKey    (inDataKey),
        .inDecrypt    (inDecrypt),
        .outBusy      (outBusy),
        .outValid     (outValid),
        .outDataState (outDataState),
        .outRound     (outRound)
    );

    // Clock generation.
    always #5 inClk = ~inClk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (word arrays, spec rules) ----------------
    function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] m_theta(input logic [127:0] k, input logic [127:0] s);
        logic [31:0] a[4];
        logic [31:0] kw[4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            a[i]  = s[127 - 32*i -: 32];
            kw[i] = k[127 - 32*i -: 32];
        end
        t = a[0] ^ a[2];
        t = t ^ m_rotl(t, 8) ^ m_rotl(t, 24);
        a[1] ^= t;
        a[3] ^= t;
        for (int i = 0; i < 4; i++) a[i] ^= kw[i];
        t = a[1] ^ a[3];
        t = t ^ m_rotl(t, 8) ^ m_rotl(t, 24);
        a[0] ^= t;
        a[2] ^= t;
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] m_pi(input logic [127:0] s, input bit inverse);
        int sh[4] = '{0, 1, 5, 2};
        logic [31:0] a[4];
        for (int i = 0; i < 4; i++) begin
            a[i] = s[127 - 32*i -: 32];
            if (sh[i] != 0) a[i] = m_rotl(a[i], inverse ? 32 - sh[i] : sh[i]);
        end
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] m_gamma(input logic [127:0] s);
        logic [31:0] a[4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) a[i] = s[127 - 32*i -: 32];
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        t = a[3]; a[3] = a[0]; a[0] = t;
        a[2] ^= a[0] ^ a[1] ^ a[3];
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] ref_cipher(input logic [127:0] txt, input logic [127:0] key,
                                                input bit dec);
        logic [7:0]   rcs[17];
        logic [127:0] s;
        logic [127:0] k;
        int v;
        rcs[0] = 8'h80;
        for (int i = 1; i < 17; i++) begin
            v = int'(rcs[i-1]) * 2;
            if (v > 255) v = v ^ 'h11B;
            rcs[i] = 8'(v);
        end
        s = txt;
        k = key;
        if (!dec) begin
            for (int r = 0; r < 16; r++)
                s = m_pi(m_gamma(m_pi(m_theta(k, s ^ {rcs[r], 120'b0}), 1'b0)), 1'b1);
            s = m_theta(k, s ^ {rcs[16], 120'b0});
        end else begin
            k = m_theta('0, k);
            for (int r = 16; r >= 1; r--)
                s = m_pi(m_gamma(m_pi(m_theta(k, s) ^ {rcs[r], 120'b0}, 1'b0)), 1'b1);
            s = m_theta(k, s) ^ {rcs[0], 120'b0};
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- driver tasks ----------------
    // One full block: checks busy/valid/round every cycle, the 17-cycle latency,
    // the single valid pulse and the held result. Optional start pulses at E3/E16.
    task automatic run_block(input logic [127:0] txt, input logic [127:0] key, input logic dec,
                             input bit inject, input logic [127:0] exp, input string tag);
        @(negedge inClk);
        inStart     = 1'b1;
        inDataState = txt;
        inDataKey   = key;
        inDecrypt   = dec;
        @(negedge inClk);
        inStart     = 1'b0;
        inDataState = rand128();
        inDataKey   = rand128();
        inDecrypt   = 1'($urandom_range(0, 1));
        for (int c = 0; c <= 16; c++) begin
            chk($sformatf("%s_round%0d", tag, c), 128'(outRound), 128'(c));
            chk($sformatf("%s_busy%0d", tag, c), 128'(outBusy), 128'(1));
            chk($sformatf("%s_novalid%0d", tag, c), 128'(outValid), 128'(0));
            if (inject && (c == 2 || c == 15)) begin
                inStart     = 1'b1;
                inDataState = rand128();
                inDataKey   = rand128();
            end else begin
                inStart = 1'b0;
            end
            @(negedge inClk);
        end
        chk($sformatf("%s_valid", tag), 128'(outValid), 128'(1));
        chk($sformatf("%s_idle", tag), 128'(outBusy), 128'(0));
        chk($sformatf("%s_data", tag), outDataState, exp);
        @(negedge inClk);
        chk($sformatf("%s_pulse_end", tag), 128'(outValid), 128'(0));
        chk($sformatf("%s_stay_idle", tag), 128'(outBusy), 128'(0));
        repeat (3) @(negedge inClk);
        chk($sformatf("%s_hold", tag), outDataState, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] pt, key, ct;
        logic [127:0] pts[3];
        logic [127:0] keys[3];
        bit           is_v;

        inRst       = 1'b1;
        inStart     = 1'b0;
        inDataState = '0;
        inDataKey   = '0;
        inDecrypt   = 1'b0;
        repeat (3) @(negedge inClk);
        chk("rst_busy", 128'(outBusy), 128'(0));
        chk("rst_valid", 128'(outValid), 128'(0));
        chk("rst_data", outDataState, 128'(0));
        chk("rst_round", 128'(outRound), 128'(0));
        inRst = 1'b0;

        // Known zero vector, all-ones plaintext, then random blocks.
        run_block('0, '0, 1'b0, 1'b0, ref_cipher('0, '0, 1'b0), "zero");
        run_block('1, '0, 1'b0, 1'b0, ref_cipher('1, '0, 1'b0), "ones");
        for (int i = 0; i < 6; i++) begin
            pt  = rand128();
            key = rand128();
            run_block(pt, key, 1'b0, (i == 2), ref_cipher(pt, key, 1'b0), $sformatf("rnd%0d", i));
        end

`ifdef NEOKEON_DECRYPT_EN
        ct = ref_cipher('0, '0, 1'b0);
        run_block(ct, '0, 1'b1, 1'b0, 128'(0), "dec_zero");
        for (int i = 0; i < 3; i++) begin
            pt  = rand128();
            key = rand128();
            ct  = ref_cipher(pt, key, 1'b0);
            run_block(ct, key, 1'b1, 1'b0, pt, $sformatf("dec_rt%0d", i));
        end
`else
        pt  = rand128();
        key = rand128();
        ct  = ref_cipher(pt, key, 1'b0);
        run_block(pt, key, 1'b1, 1'b0, ct, "dec_ignored");
`endif

        // inStart held high: a new block every 18 cycles.
        for (int i = 0; i < 3; i++) begin
            pts[i]  = rand128();
            keys[i] = rand128();
            exp_q.push_back(ref_cipher(pts[i], keys[i], 1'b0));
        end
        @(negedge inClk);
        inStart     = 1'b1;
        inDecrypt   = 1'b0;
        inDataState = pts[0];
        inDataKey   = keys[0];
        for (int c = 0; c <= 53; c++) begin
            @(negedge inClk);
            is_v = (c == 17 || c == 35 || c == 53);
            chk($sformatf("held_valid%0d", c), 128'(outValid), 128'(is_v));
            chk($sformatf("held_busy%0d", c), 128'(outBusy), 128'(!is_v));
            if (is_v) begin
                if (exp_q.size() > 0) chk($sformatf("held_data%0d", c), outDataState, exp_q.pop_front());
                else chk($sformatf("held_queue%0d", c), 128'(0), 128'(1));
            end
            if (c == 0) begin
                inDataState = pts[1];
                inDataKey   = keys[1];
            end
            if (c == 18) begin
                inDataState = pts[2];
                inDataKey   = keys[2];
            end
            if (c == 53) inStart = 1'b0;
        end
        @(negedge inClk);
        chk("held_stop_busy", 128'(outBusy), 128'(0));
        chk("held_stop_valid", 128'(outValid), 128'(0));

        // Reset mid-operation, held with inStart asserted: no result appears.
        @(negedge inClk);
        inStart     = 1'b1;
        inDataState = rand128();
        inDataKey   = rand128();
        @(negedge inClk);
        inStart = 1'b0;
        repeat (8) @(negedge inClk);
        chk("abort_busy_before", 128'(outBusy), 128'(1));
        inRst   = 1'b1;
        inStart = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge inClk);
            chk($sformatf("abort_valid%0d", c), 128'(outValid), 128'(0));
            chk($sformatf("abort_busy%0d", c), 128'(outBusy), 128'(0));
        end
        chk("abort_data", outDataState, 128'(0));
        chk("abort_round", 128'(outRound), 128'(0));
        inStart = 1'b0;
        @(negedge inClk);
        inRst = 1'b0;
        repeat (20) begin
            @(negedge inClk);
            chk("post_abort_valid", 128'(outValid), 128'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
